// File: rtl/cic_rate_ctrl_if.sv
// cic_rate_ctrl_if: valid/ready output stream carrying decimated samples
interface cic_rate_ctrl_if #(
    parameter int INPUTWIDTH = 8
);
    logic                         m_valid;
    logic                         m_ready;
    logic signed [INPUTWIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl: CIC decimation-factor change sequencer and output gate; define CIC_DROP_CNT_EN to add the drop_cnt port
module cic_rate_ctrl #(
    parameter int INPUTWIDTH     = 8,
    parameter int N              = 4,
    parameter int MAX_D          = 16,
    parameter int DEFAULT_D      = 4,
    parameter int RST_CYCLES     = 2,
    parameter int SETTLE_SAMPLES = N + 2,
    localparam int DW            = $clog2(MAX_D) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [DW-1:0]                cfg_d,
    output logic                         cfg_err,
    output logic                         busy,
    output logic                         cic_rst,
    output logic [DW-1:0]                cic_d,
    input  logic                         cic_dclk,
    input  logic signed [INPUTWIDTH-1:0] cic_dout,
    cic_rate_ctrl_if.master              m
`ifdef CIC_DROP_CNT_EN
    ,
    output logic [15:0]                  drop_cnt
`endif
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_SAMPLES + 1);

    typedef enum logic [1:0] {FLUSH, SETTLE, RUN} state_t;

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic [SW-1:0] settle_cnt;
    logic          cfg_legal;
    logic          accept;
    logic          load;
    logic          drop;

    assign cfg_ready = state == RUN;

    // request decode and output-register load/drop decisions
    always_comb begin
        cfg_legal = cfg_d >= DW'(2) && cfg_d <= DW'(MAX_D) && (cfg_d & (cfg_d - DW'(1))) == '0;
        accept    = cfg_valid && cfg_ready;
        load      = cfg_ready && cic_dclk && (!m.m_valid || m.m_ready);
        drop      = cfg_ready && cic_dclk && m.m_valid && !m.m_ready;
    end

    // rate-change sequencer: hold the filter in reset, then discard transient samples
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FLUSH;
            cic_rst    <= 1'b1;
            cic_d      <= DW'(DEFAULT_D);
            busy       <= 1'b1;
            cfg_err    <= 1'b0;
            rst_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            cfg_err <= accept && !cfg_legal;
            case (state)
                FLUSH: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        state   <= SETTLE;
                        cic_rst <= 1'b0;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cic_dclk) begin
                        if (settle_cnt == SW'(SETTLE_SAMPLES - 1)) begin
                            state      <= RUN;
                            busy       <= 1'b0;
                            settle_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (accept && cfg_legal) begin
                        state   <= FLUSH;
                        cic_d   <= cfg_d;
                        cic_rst <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // one-entry output register; a pending sample outlives a rate change
    always_ff @(posedge clk) begin
        if (rst) begin
            m.m_valid <= 1'b0;
            m.m_data  <= '0;
        end else if (load) begin
            m.m_valid <= 1'b1;
            m.m_data  <= cic_dout;
        end else if (m.m_ready) begin
            m.m_valid <= 1'b0;
        end
    end

`ifdef CIC_DROP_CNT_EN
    // saturating count of samples lost to backpressure since the last rate change
    always_ff @(posedge clk) begin
        if (rst || (accept && cfg_legal))
            drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_cic_rate_ctrl.sv
// tb_cic_rate_ctrl: randomized scoreboard bench for cic_rate_ctrl against a behavioural model
module tb_cic_rate_ctrl;
    localparam int W      = 8;
    localparam int MAX_D  = 16;
    localparam int DW     = 5;
    localparam int RST_C  = 2;
    localparam int SETTLE = 6;
    localparam int DEF_D  = 4;
    localparam int CYCLES = 4000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [DW-1:0]       cfg_d = '0;
    logic                cfg_err;
    logic                busy;
    logic                cic_rst;
    logic [DW-1:0]       cic_d;
    logic                cic_dclk = 1'b0;
    logic signed [W-1:0] cic_dout = '0;
`ifdef CIC_DROP_CNT_EN
    logic [15:0]         drop_cnt;
`endif

    cic_rate_ctrl_if #(.INPUTWIDTH(W)) m ();

    cic_rate_ctrl #(.INPUTWIDTH(W), .MAX_D(MAX_D), .DEFAULT_D(DEF_D), .RST_CYCLES(RST_C), .SETTLE_SAMPLES(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_d     (cfg_d),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .cic_rst   (cic_rst),
        .cic_d     (cic_d),
        .cic_dclk  (cic_dclk),
        .cic_dout  (cic_dout),
        .m         (m.master)
`ifdef CIC_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int handshakes = 0;
    int accepts = 0;
    int rejects = 0;
    logic signed [W-1:0] sb[$];

    // model: flush cycles left, settle strobes left, pending output sample
    int                  flush_left;
    int                  settle_left;
    bit                  pv;
    logic signed [W-1:0] pd;
    bit                  data_zero;
    int                  md;
    bit                  merr;
    int                  mdrop;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit legal(input int d);
        return d >= 2 && d <= MAX_D && (d & (d - 1)) == 0;
    endfunction

    task automatic model_reset();
        flush_left  = RST_C;
        settle_left = SETTLE;
        pv          = 1'b0;
        pd          = '0;
        data_zero   = 1'b1;
        md          = DEF_D;
        merr        = 1'b0;
        mdrop       = 0;
    endtask

    // advance the model across the coming clock edge with the inputs now driven
    task automatic model_step();
        bit run;
        bit drop;
        bit acc_legal;
        if (pv && m.m_ready)
            sb.push_back(pd);
        if (rst) begin
            model_reset();
        end else begin
            run       = flush_left == 0 && settle_left == 0;
            merr      = 1'b0;
            acc_legal = run && cfg_valid && legal(int'(cfg_d));
            drop      = run && cic_dclk && pv && !m.m_ready;
            if (run && cic_dclk && (!pv || m.m_ready)) begin
                pd        = cic_dout;
                pv        = 1'b1;
                data_zero = 1'b0;
            end else if (m.m_ready) begin
                pv = 1'b0;
            end
            if (acc_legal)
                mdrop = 0;
            else if (drop && mdrop < 65535)
                mdrop++;
            if (flush_left > 0) begin
                flush_left--;
            end else if (settle_left > 0) begin
                if (cic_dclk)
                    settle_left--;
            end else if (cfg_valid) begin
                if (acc_legal) begin
                    md          = int'(cfg_d);
                    flush_left  = RST_C;
                    settle_left = SETTLE;
                    accepts++;
                end else begin
                    merr = 1'b1;
                    rejects++;
                end
            end
        end
    endtask

    // monitor: every output handshake pops the scoreboard
    initial begin
        logic signed [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (m.m_valid && m.m_ready) begin
                handshakes++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow got=%0d expected=none at %0t", m.m_data, $time);
                end else begin
                    exp = sb.pop_front();
                    check("m_data", int'(m.m_data), int'(exp));
                end
            end
        end
    end

    // driver: check registered outputs after each edge, then drive random inputs
    initial begin
        int rp;
        m.m_ready = 1'b1;
        model_reset();
        rp = 100;
        for (int i = 0; i < CYCLES; i++) begin
            @(posedge clk);
            #1;
            check("cic_rst", int'(cic_rst), int'(flush_left > 0));
            check("busy", int'(busy), int'(flush_left > 0 || settle_left > 0));
            check("cfg_ready", int'(cfg_ready), int'(flush_left == 0 && settle_left == 0));
            check("cic_d", int'(cic_d), md);
            check("cfg_err", int'(cfg_err), int'(merr));
            check("m_valid", int'(m.m_valid), int'(pv));
            if (data_zero)
                check("m_data_reset", int'(m.m_data), 0);
`ifdef CIC_DROP_CNT_EN
            check("drop_cnt", int'(drop_cnt), mdrop);
`endif
            if (i % 400 == 0)
                rp = (i / 400) % 3 == 0 ? 100 : $urandom_range(10, 90);
            rst       = i < 3 || $urandom_range(0, 599) == 0;
            m.m_ready = $urandom_range(1, 100) <= rp;
            cic_dclk  = $urandom_range(0, 9) < 4;
            cic_dout  = W'($urandom);
            cfg_valid = $urandom_range(0, 9) == 0;
            cfg_d     = $urandom_range(0, 1) == 0 ? DW'($urandom_range(0, 31)) : DW'(1 << $urandom_range(1, 4));
            model_step();
        end
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("handshakes_seen", int'(handshakes > 50), 1);
        check("accepts_seen", int'(accepts > 5), 1);
        check("rejects_seen", int'(rejects > 5), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
